// File: rtl/wino_data_buffer.sv
// rtl/wino_data_buffer.sv - Winograd input-activation buffer: scan load port, optional ping-pong banks,
// NUM_RD fully pipelined read ports with fixed RD_LAT latency.
module wino_data_buffer #(
  parameter int DATA_W     = 512,
  parameter int DEPTH      = 128,
  parameter int NUM_RD     = 2,
  parameter int RD_LAT     = 1,
  parameter int DOUBLE_BUF = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        scan_in,
  input  logic                     scan_valid,
  input  logic                     scan_restart,
  input  logic                     swap,
  input  logic [NUM_RD*AW-1:0]     rd_addr_in,
  input  logic [NUM_RD-1:0]        rd_valid_in,
  output logic [NUM_RD*DATA_W-1:0] rd_data_out,
  output logic [NUM_RD*AW-1:0]     rd_addr_out,
  output logic [NUM_RD-1:0]        rd_valid_out,
  output logic [NUM_RD-1:0]        rd_drop_out,
  output logic [AW:0]              load_count,
  output logic                     load_full,
  output logic                     overflow,
  output logic                     rd_bank
);

  localparam int CW        = AW + 1;
  localparam bit PING_PONG = (DOUBLE_BUF != 0);

  // Both banks live in one array addressed by {bank, word}; a single-bank build never touches the upper half.
  logic [DATA_W-1:0] mem [2*DEPTH];

  logic [AW:0] load_count_q, load_count_d;
  logic        overflow_q, overflow_d;
  logic        rd_bank_q, rd_bank_d;
  logic        full, wr_en, do_swap, clear_load, load_bank, read_blocked;
  logic [AW:0] wr_addr;

  logic [NUM_RD-1:0] vld_q [RD_LAT];
  logic [NUM_RD-1:0] vld_d [RD_LAT];
  logic [NUM_RD-1:0] drp_q [RD_LAT];
  logic [NUM_RD-1:0] drp_d [RD_LAT];
  logic [AW-1:0]     adr_q [RD_LAT][NUM_RD];
  logic [AW-1:0]     adr_d [RD_LAT][NUM_RD];
  logic [DATA_W-1:0] dat_q [RD_LAT][NUM_RD];
  logic [DATA_W-1:0] dat_d [RD_LAT][NUM_RD];

  always_comb begin
    full         = (load_count_q == CW'(DEPTH));
    do_swap      = PING_PONG && swap;
    clear_load   = scan_restart || do_swap;
    load_bank    = PING_PONG ? ~rd_bank_q : 1'b0;
    wr_en        = scan_valid && !full && !scan_restart;
    wr_addr      = {load_bank, load_count_q[AW-1:0]};
    load_count_d = load_count_q;
    overflow_d   = overflow_q;
    rd_bank_d    = rd_bank_q ^ do_swap;
    if (wr_en) load_count_d = load_count_q + CW'(1);
    if (scan_valid && full) overflow_d = 1'b1;
    // A same-cycle write still lands at the old pointer before the load state clears.
    if (clear_load) begin
      load_count_d = '0;
      overflow_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_addr] <= scan_in;
  end

  always_comb begin
    vld_d = vld_q;
    drp_d = drp_q;
    adr_d = adr_q;
    dat_d = dat_q;
    read_blocked = !PING_PONG && scan_valid;
    vld_d[0] = read_blocked ? '0 : rd_valid_in;
    drp_d[0] = read_blocked ? rd_valid_in : '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (vld_d[0][p]) begin
        adr_d[0][p] = rd_addr_in[p*AW +: AW];
        dat_d[0][p] = mem[{rd_bank_q, rd_addr_in[p*AW +: AW]}];
      end
    end
    // Data/address stages only advance on valid so the outputs hold the last returned word.
    for (int s = 1; s < RD_LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      drp_d[s] = drp_q[s-1];
      for (int p = 0; p < NUM_RD; p++) begin
        if (vld_q[s-1][p]) begin
          adr_d[s][p] = adr_q[s-1][p];
          dat_d[s][p] = dat_q[s-1][p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_count_q <= '0;
      overflow_q   <= 1'b0;
      rd_bank_q    <= 1'b0;
      for (int s = 0; s < RD_LAT; s++) begin
        vld_q[s] <= '0;
        drp_q[s] <= '0;
        for (int p = 0; p < NUM_RD; p++) begin
          adr_q[s][p] <= '0;
          dat_q[s][p] <= '0;
        end
      end
    end else begin
      load_count_q <= load_count_d;
      overflow_q   <= overflow_d;
      rd_bank_q    <= rd_bank_d;
      vld_q        <= vld_d;
      drp_q        <= drp_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_out
    assign rd_data_out[p*DATA_W +: DATA_W] = dat_q[RD_LAT-1][p];
    assign rd_addr_out[p*AW +: AW]         = adr_q[RD_LAT-1][p];
  end

  assign rd_valid_out = vld_q[RD_LAT-1];
  assign rd_drop_out  = drp_q[RD_LAT-1];
  assign load_count   = load_count_q;
  assign load_full    = full;
  assign overflow     = overflow_q;
  assign rd_bank      = rd_bank_q;

endmodule
